// File: rtl/dbg_scan_mux.sv
// Debug-view scanner: steps through NCH probe channels one entry per advance, fetching
// each entry over a req/valid handshake and holding the last result for the display.
module dbg_scan_mux #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 6,
  parameter int unsigned DIV_W    = 28,
  parameter int unsigned SLOW_B   = 27,
  parameter int unsigned FAST_B   = 25,
  parameter int unsigned TO_CYC   = 15,
  parameter logic [DW-1:0] END_MARK = 32'hFFFFFFFF,
  parameter logic [DW-1:0] TO_MARK  = 32'hDEADBEEF,
  localparam int unsigned CW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NCH-1:0]    ch_sel,
  input  logic              run,
  input  logic              step,
  input  logic              fast_sel,
  input  logic [NCH*AW-1:0] depth,
  output logic              rd_req,
  output logic [CW-1:0]     rd_ch,
  output logic [AW-1:0]     rd_addr,
  input  logic              rd_valid,
  input  logic [DW-1:0]     rd_data,
  output logic [DW-1:0]     disp_data,
  output logic [CW-1:0]     disp_ch,
  output logic [AW-1:0]     disp_idx,
  output logic              disp_upd,
  output logic              busy
);

  localparam int unsigned PW = $clog2(DIV_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nx;
  logic [DIV_W-1:0] div_q;
  logic [PW-1:0]   tick_pos;
  logic            tick_bit, tick_prev, tick;
  logic            step_q, step_rise, adv;
  logic            onehot;
  logic [CW-1:0]   cur;
  logic [AW-1:0]   idx_q [NCH];
  logic [AW-1:0]   depth_cur, idx_cur;
  logic [7:0]      to_cnt;
  logic            go_read, go_end, rd_done, rd_to;

  // Tick source selection and edge detection
  assign tick_pos  = fast_sel ? PW'(FAST_B) : PW'(SLOW_B);
  assign tick_bit  = div_q[tick_pos];
  assign tick      = tick_bit & ~tick_prev;
  assign step_rise = step & ~step_q;
  assign adv       = run ? tick : step_rise;

  // Zero or multi-hot selections fall back to channel 0
  assign onehot = (ch_sel != '0) && ((ch_sel & (ch_sel - NCH'(1))) == '0);

  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_sel[i]) cur = CW'(i);
    end
    if (!onehot) cur = '0;
  end

  assign depth_cur = depth[int'(cur)*AW +: AW];
  assign idx_cur   = idx_q[cur];

  // idx >= depth (not just ==) also catches a depth lowered below the saved index
  assign go_end  = (state == IDLE) && adv && (depth_cur != '0) && (idx_cur >= depth_cur);
  assign go_read = (state == IDLE) && adv && (depth_cur != '0) && (idx_cur < depth_cur);
  assign rd_done = (state == WAIT) && rd_valid;
  assign rd_to   = (state == WAIT) && !rd_valid && (to_cnt == 8'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go_read) state_nx = REQ;
      REQ:     state_nx = WAIT;
      WAIT:    if (rd_done || rd_to) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_req = (state == REQ) || (state == WAIT);
    busy   = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      div_q     <= '0;
      tick_prev <= 1'b0;
      step_q    <= 1'b0;
      rd_ch     <= '0;
      rd_addr   <= '0;
      to_cnt    <= '0;
      disp_data <= '0;
      disp_ch   <= '0;
      disp_idx  <= '0;
      disp_upd  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) idx_q[c] <= '0;
    end else begin
      div_q     <= div_q + DIV_W'(1);
      tick_prev <= tick_bit;
      step_q    <= step;
      disp_upd  <= 1'b0;

      if (go_read) begin
        rd_ch   <= cur;
        rd_addr <= idx_cur;
      end

      if (go_end) begin
        disp_data  <= END_MARK;
        disp_ch    <= cur;
        disp_idx   <= depth_cur;
        disp_upd   <= 1'b1;
        idx_q[cur] <= '0;
      end

      // Counts WAIT cycles without rd_valid; cleared in REQ so each read starts fresh
      if (state == REQ)
        to_cnt <= '0;
      else if ((state == WAIT) && !rd_valid)
        to_cnt <= to_cnt + 8'd1;

      if (rd_done || rd_to) begin
        disp_data    <= rd_done ? rd_data : TO_MARK;
        disp_ch      <= rd_ch;
        disp_idx     <= rd_addr;
        disp_upd     <= 1'b1;
        idx_q[rd_ch] <= rd_addr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dbg_scan_mux.sv
// Self-checking bench for dbg_scan_mux: random probe memory and a per-channel index model.
module tb_dbg_scan_mux;

  localparam int NCH = 4;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO_CYC = 15;
  localparam logic [31:0] END_MARK = 32'hFFFFFFFF;
  localparam logic [31:0] TO_MARK  = 32'hDEADBEEF;

  logic              clk;
  logic              rstn;
  logic [NCH-1:0]    ch_sel;
  logic              run, step, fast_sel;
  logic [NCH*AW-1:0] depth;
  logic              rd_req;
  logic [1:0]        rd_ch;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic [DW-1:0]     disp_data;
  logic [1:0]        disp_ch;
  logic [AW-1:0]     disp_idx;
  logic              disp_upd, busy;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem [NCH][64];
  int          m_idx [NCH];
  int          m_depth [NCH];
  int          vdelay = 0;
  logic [15:0] req_cnt = '0;

  dbg_scan_mux #(
    .NCH(NCH), .DW(DW), .AW(AW), .DIV_W(28), .SLOW_B(27), .FAST_B(3),
    .TO_CYC(TO_CYC), .END_MARK(END_MARK), .TO_MARK(TO_MARK)
  ) dut (
    .clk(clk), .rstn(rstn), .ch_sel(ch_sel), .run(run), .step(step),
    .fast_sel(fast_sel), .depth(depth), .rd_req(rd_req), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .disp_data(disp_data), .disp_ch(disp_ch), .disp_idx(disp_idx),
    .disp_upd(disp_upd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Probe responder: valid once rd_req has been high for vdelay cycles
  always @(posedge clk) req_cnt <= rd_req ? req_cnt + 16'd1 : 16'd0;
  assign rd_valid = (int'(req_cnt) >= vdelay);
  assign rd_data  = mem[rd_ch][rd_addr];

  function automatic int exp_cur(input logic [3:0] s);
    int n = 0;
    int p = 0;
    for (int i = 0; i < 4; i++) if (s[i]) begin n++; p = i; end
    return (n == 1) ? p : 0;
  endfunction

  // kind: 0 = channel disabled, 1 = end marker, 2 = read of entry addr
  task automatic model_adv(input int ch, output int kind, output int addr);
    if (m_depth[ch] == 0) begin
      kind = 0; addr = 0;
    end else if (m_idx[ch] >= m_depth[ch]) begin
      kind = 1; addr = m_depth[ch]; m_idx[ch] = 0;
    end else begin
      kind = 2; addr = m_idx[ch]; m_idx[ch] = m_idx[ch] + 1;
    end
  endtask

  task automatic set_depth(input int c, input int v);
    m_depth[c] = v;
    depth[c*AW +: AW] = AW'(v);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  // One step pulse; reports the first disp_upd within maxw cycles and the first request seen
  task automatic pulse_step(input int maxw, output bit got, output int lat, output logic [31:0] d,
                            output int dch, output int didx, output bit rseen,
                            output int rch, output int raddr);
    got = 0; lat = 0; d = '0; dch = 0; didx = 0; rseen = 0; rch = 0; raddr = 0;
    step = 1'b1;
    for (int k = 1; k <= maxw; k++) begin
      @(posedge clk); #1;
      if (k == 1) step = 1'b0;
      if (rd_req && !rseen) begin rseen = 1; rch = int'(rd_ch); raddr = int'(rd_addr); end
      if (disp_upd) begin
        got = 1; lat = k; d = disp_data; dch = int'(disp_ch); didx = int'(disp_idx);
        break;
      end
    end
    step = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    cyc(2);
    n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (disp_data !== 32'h0) begin n_fail++; $display("FAIL reset_disp_data: got %h expected 0", disp_data); end
    n_checks++; if (disp_upd !== 1'b0) begin n_fail++; $display("FAIL reset_disp_upd: got %b expected 0", disp_upd); end
    n_checks++; if ({rd_ch, rd_addr, disp_ch, disp_idx} !== '0) begin n_fail++; $display("FAIL reset_idx_ch: got %h expected 0", {rd_ch, rd_addr, disp_ch, disp_idx}); end
    rstn = 1'b0;
    cyc(1);
  endtask

  task automatic test_scan;
    bit got, rs; int lat, dch, didx, rch, ra, kind, addr; logic [31:0] d;
    vdelay = 0; ch_sel = 4'b0100; set_depth(2, 3);
    for (int i = 0; i < 5; i++) begin
      model_adv(2, kind, addr);
      pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
      n_checks++; if (!got || lat != (kind == 1 ? 1 : 3)) begin n_fail++; $display("FAIL scan_latency[%0d]: got %0d expected %0d", i, lat, kind == 1 ? 1 : 3); end
      n_checks++; if (d !== (kind == 1 ? END_MARK : mem[2][addr])) begin n_fail++; $display("FAIL scan_data[%0d]: got %h expected %h", i, d, kind == 1 ? END_MARK : mem[2][addr]); end
      n_checks++; if (didx != addr || dch != 2) begin n_fail++; $display("FAIL scan_pos[%0d]: got ch%0d/%0d expected ch2/%0d", i, dch, didx, addr); end
    end
  endtask

  task automatic test_retain;
    bit got, rs; int lat, dch, didx, rch, ra, kind, addr; logic [31:0] d;
    set_depth(0, 5); set_depth(3, 5);
    ch_sel = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      model_adv(0, kind, addr);
      pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
      n_checks++; if (d !== mem[0][addr]) begin n_fail++; $display("FAIL retain_ch0_data[%0d]: got %h expected %h", i, d, mem[0][addr]); end
    end
    ch_sel = 4'b1000;
    model_adv(3, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (d !== mem[3][addr] || dch != 3) begin n_fail++; $display("FAIL retain_ch3: got ch%0d %h expected ch3 %h", dch, d, mem[3][addr]); end
    ch_sel = 4'b0001;
    model_adv(0, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (!rs || rch != 0 || ra != addr) begin n_fail++; $display("FAIL retain_resume: got ch%0d addr %0d expected ch0 addr %0d", rch, ra, addr); end
  endtask

  task automatic test_timeout;
    bit got, rs; int lat, dch, didx, rch, ra, kind, addr; logic [31:0] d;
    ch_sel = 4'b0001; vdelay = 255;
    model_adv(0, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (!got || lat != TO_CYC + 2) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TO_CYC + 2); end
    n_checks++; if (d !== TO_MARK) begin n_fail++; $display("FAIL timeout_data: got %h expected %h", d, TO_MARK); end
    vdelay = 0;
    model_adv(0, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (ra != addr || d !== mem[0][addr]) begin n_fail++; $display("FAIL timeout_next_addr: got %0d/%h expected %0d/%h", ra, d, addr, mem[0][addr]); end
  endtask

  task automatic test_chsel;
    bit got, rs; int lat, dch, didx, rch, ra, kind, addr; logic [31:0] d, held;
    set_depth(0, 40);
    ch_sel = 4'b0110;
    model_adv(exp_cur(ch_sel), kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (!rs || rch != 0 || ra != addr) begin n_fail++; $display("FAIL multihot_ch: got ch%0d addr %0d expected ch0 addr %0d", rch, ra, addr); end
    ch_sel = 4'b0000;
    model_adv(exp_cur(ch_sel), kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (!rs || rch != 0 || ra != addr) begin n_fail++; $display("FAIL zerohot_ch: got ch%0d addr %0d expected ch0 addr %0d", rch, ra, addr); end
    // Lowering depth under the saved index gives the end marker at the new depth
    set_depth(0, 3);
    model_adv(0, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (!got || lat != 1 || d !== END_MARK || didx != addr || rs) begin n_fail++; $display("FAIL lowered_depth: got lat %0d %h idx %0d req %0b expected lat 1 %h idx %0d req 0", lat, d, didx, rs, END_MARK, addr); end
    ch_sel = 4'b0001;
    model_adv(0, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (ra != addr) begin n_fail++; $display("FAIL wrap_addr: got %0d expected %0d", ra, addr); end
    held = mem[0][addr];
    set_depth(0, 0);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (got || rs || disp_data !== held) begin n_fail++; $display("FAIL disabled_ch: got upd %0b req %0b data %h expected 0 0 %h", got, rs, disp_data, held); end
  endtask

  task automatic test_reset_mid;
    bit got, rs; int lat, dch, didx, rch, ra, kind, addr, nupd; logic [31:0] d;
    ch_sel = 4'b0100; vdelay = 255;
    step = 1'b1; cyc(1); step = 1'b0; cyc(3);
    n_checks++; if (busy !== 1'b1 || rd_req !== 1'b1) begin n_fail++; $display("FAIL midread_busy: got %b/%b expected 1/1", busy, rd_req); end
    rstn = 1'b1; cyc(2);
    n_checks++; if (rd_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got req %b busy %b expected 0 0", rd_req, busy); end
    n_checks++; if (disp_data !== 32'h0 || disp_upd !== 1'b0) begin n_fail++; $display("FAIL midreset_disp: got %h upd %b expected 0 0", disp_data, disp_upd); end
    rstn = 1'b0;
    for (int c = 0; c < NCH; c++) m_idx[c] = 0;
    nupd = 0;
    for (int i = 0; i < 20; i++) begin cyc(1); if (disp_upd) nupd++; end
    n_checks++; if (nupd != 0) begin n_fail++; $display("FAIL midreset_no_upd: got %0d expected 0", nupd); end
    vdelay = 0;
    model_adv(2, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (ra != addr || d !== mem[2][addr]) begin n_fail++; $display("FAIL midreset_idx2: got %0d expected %0d", ra, addr); end
    ch_sel = 4'b1000;
    model_adv(3, kind, addr);
    pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
    n_checks++; if (ra != addr) begin n_fail++; $display("FAIL midreset_idx3: got %0d expected %0d", ra, addr); end
  endtask

  task automatic test_random;
    bit got, rs; int lat, dch, didx, rch, ra, kind, addr, c, elat; logic [31:0] d, ed;
    for (int i = 0; i < NCH; i++) set_depth(i, $urandom_range(1, 7));
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) ch_sel = 4'($urandom);
      else ch_sel = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) set_depth($urandom_range(0, 3), $urandom_range(0, 7));
      vdelay = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 20) : 0;
      c = exp_cur(ch_sel);
      model_adv(c, kind, addr);
      pulse_step(25, got, lat, d, dch, didx, rs, rch, ra);
      if (kind == 0) begin
        n_checks++; if (got || rs) begin n_fail++; $display("FAIL rnd_disabled[%0d]: got upd %0b req %0b expected 0 0", it, got, rs); end
      end else if (kind == 1) begin
        n_checks++; if (!got || lat != 1 || d !== END_MARK || didx != addr || dch != c) begin n_fail++; $display("FAIL rnd_end[%0d]: got lat %0d %h ch%0d/%0d expected 1 %h ch%0d/%0d", it, lat, d, dch, didx, END_MARK, c, addr); end
      end else begin
        elat = (vdelay >= 16) ? TO_CYC + 2 : 2 + ((vdelay < 1) ? 1 : vdelay);
        ed = (vdelay >= 16) ? TO_MARK : mem[c][addr];
        n_checks++; if (!rs || rch != c || ra != addr) begin n_fail++; $display("FAIL rnd_req[%0d]: got ch%0d/%0d expected ch%0d/%0d", it, rch, ra, c, addr); end
        n_checks++; if (!got || lat != elat || d !== ed) begin n_fail++; $display("FAIL rnd_disp[%0d]: got lat %0d %h expected lat %0d %h", it, lat, d, elat, ed); end
      end
    end
  endtask

  task automatic test_freerun;
    int kind, addr, nreq, nupd, last, moved, bad_data;
    bit prev_req, prev_seen;
    logic [AW-1:0] prev_addr;
    ch_sel = 4'b0001; set_depth(0, 60); vdelay = 20;
    fast_sel = 1'b1; cyc(20);
    run = 1'b1;
    nreq = 0; nupd = 0; last = 0; moved = 0; bad_data = 0; prev_req = 0; prev_seen = 0; prev_addr = '0;
    // Each read times out after 16 busy cycles, so the tick landing in its last cycle is dropped
    for (int t = 1; t <= 400; t++) begin
      cyc(1);
      if (rd_req && !prev_req) begin
        nreq++;
        model_adv(0, kind, addr);
        n_checks++; if (int'(rd_addr) != addr) begin n_fail++; $display("FAIL free_addr[%0d]: got %0d expected %0d", nreq, rd_addr, addr); end
        if (nreq > 1) begin
          n_checks++; if (t - last != 32) begin n_fail++; $display("FAIL free_spacing[%0d]: got %0d expected 32", nreq, t - last); end
        end
        last = t;
      end else if (rd_req && prev_seen && rd_addr !== prev_addr) moved++;
      if (disp_upd) begin nupd++; if (disp_data !== TO_MARK) bad_data++; end
      prev_req = rd_req; prev_seen = rd_req; prev_addr = rd_addr;
    end
    run = 1'b0;
    for (int t = 0; t < 40 && busy; t++) begin
      cyc(1);
      if (disp_upd) begin nupd++; if (disp_data !== TO_MARK) bad_data++; end
    end
    cyc(2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL free_drain: got busy %b expected 0", busy); end
    n_checks++; if (nupd != nreq) begin n_fail++; $display("FAIL free_one_outstanding: got %0d updates expected %0d", nupd, nreq); end
    n_checks++; if (nreq < 12) begin n_fail++; $display("FAIL free_read_count: got %0d expected >= 12", nreq); end
    n_checks++; if (moved != 0 || bad_data != 0) begin n_fail++; $display("FAIL free_stable: got %0d addr moves %0d bad data expected 0 0", moved, bad_data); end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_idx[c] = 0; m_depth[c] = 0;
      for (int a = 0; a < 64; a++) mem[c][a] = $urandom;
    end
    rstn = 1'b1; ch_sel = '0; run = 1'b0; step = 1'b0; fast_sel = 1'b0; depth = '0;
    @(posedge clk); #1;
    test_reset();
    test_scan();
    test_retain();
    test_timeout();
    test_chsel();
    test_reset_mid();
    test_random();
    test_freerun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
